serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that sequences a single 1-bit `full_adder` cell over a WIDTH-bit operand pair, one bit per clock, LSB first. The carry is held in a flip-flop between bit-steps. A Start/Done handshake frames each operation. The block lets the team build multi-bit addition from the existing 1-bit adder at minimal area, and it sits between a requesting datapath and the shared `full_adder` instance.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  request; accepted only on a cycle where Ready=1.
- A  input  WIDTH  operand A; sampled on the accept cycle only.
- B  input  WIDTH  operand B; sampled on the accept cycle only.
- Cin  input  1  carry-in; sampled on the accept cycle only.
- Ready  output  1  high in IDLE and DONE; the block can accept Start.
- Busy  output  1  high in RUN.
- Done  output  1  one-cycle pulse; Sum/Cout are valid.
- Sum  output  WIDTH  result; held until the next completion or reset.
- Cout  output  1  final carry-out; held with Sum.

## Operation
- States:
  - IDLE: Ready=1. Start → RUN. Latch A and B into shift registers, Cin into the carry flop, and clear the bit counter.
  - RUN: Busy=1. Each cycle:
    - Drive the full_adder with A_sr[0], B_sr[0] and the carry flop.
    - Shift the adder Sum bit into the MSB of the result shift register.
    - Shift A_sr and B_sr right.
    - Carry flop ← adder Cout; counter +1.
    - When counter == WIDTH-1, this cycle is the last bit → DONE.
  - DONE: Done=1 and Ready=1 for one cycle. Sum ← result register, Cout ← carry flop (registered on the RUN→DONE edge). Start → RUN (back-to-back, same latch actions as IDLE); otherwise → IDLE.
- Start while Busy=1 is ignored, with no queuing and no error.
- Operands may change freely after the accept cycle.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1), unsigned.
- Counter width is $clog2(WIDTH). The counter saturates logic-free because the terminal compare is at WIDTH-1; there is no wrap.
- Rst asserted at any time, including mid-RUN, aborts the operation: state → IDLE, partial results discarded, no Done.

## Timing
- Reset values: Ready=1, Busy=0, Done=0, Sum=0, Cout=0. Internal shift registers, carry flop and counter = 0.
- Accept at edge k. RUN occupies cycles k+1 … k+WIDTH. Done is high in cycle k+WIDTH+1, and Sum/Cout update on that same edge.
- Latency: WIDTH+1 cycles, Start-accept edge to Done.
- Throughput: one operation per WIDTH+1 cycles with back-to-back Start in DONE.
- Done never asserts on two consecutive cycles.
- Sum/Cout are stable from the Done edge until the next Done edge or reset; they do not change during RUN.

## Configuration
- SERIAL_ADD_OVF_EN, when defined:
  - Adds output port Ovf (1 bit, reset 0).
  - Ovf = carry into the MSB XOR final carry-out, i.e. two's-complement signed overflow.
  - Ovf updates with Sum/Cout on the Done edge.
  - Requires one extra flop capturing the carry before the last bit-step.
- When undefined: the Ovf port, the extra flop and the logic are absent, and all other behaviour is identical.

## Structure
- Shared package serial_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH constant.
- Sub-module: the existing `full_adder` (ports A, B, Cin, Sum, Cout), instantiated once. The controller contains no other adder logic.

## Test plan
All scenarios use WIDTH=8.
- Reset, then 0x00+0x00, Cin=0: after 9 cycles Done=1, Sum=0x00, Cout=0. Ready=1 out of reset, Busy=0.
- 0xFF+0x01, Cin=0 → Sum=0x00, Cout=1. Then 0xA5+0x5A, Cin=1 → Sum=0x00, Cout=1. With SERIAL_ADD_OVF_EN, Ovf=0 for both.
- With SERIAL_ADD_OVF_EN: 0x7F+0x01, Cin=0 → Sum=0x80, Cout=0, Ovf=1. Then 0x80+0x80 → Sum=0x00, Cout=1, Ovf=1.
- Start pulsed with new operands 3 cycles into RUN → ignored. Result matches the first operation only, and a single Done appears at cycle 9.
- Back-to-back: Start held high in the DONE cycle with 0x12+0x34 → the second Done lands exactly 9 cycles later with Sum=0x46. Sum holds the first result until then.
- Rst asserted mid-RUN (cycle 4) → next cycle Ready=1, Busy=0, Sum=0, Cout=0. No Done for the aborted operation. A following 0x01+0x01 gives Sum=0x02.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and default width for the bit-serial adder controller
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell shared by the serial adder controller
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  // Sum is the three-way parity; carry is the majority of the three inputs
  always_comb begin
    Sum  = A ^ B ^ Cin;
    Cout = (A & B) | (Cin & (A ^ B));
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, LSB first, optional Ovf output under SERIAL_ADD_OVF_EN
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the upper WIDTH-1 result bits; the final bit joins them on the last step
  logic [WIDTH-2:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // Result after inserting this step's sum bit at the MSB end
  assign res_next = {fa_sum, res_sr};

  // Controller FSM: latch operands on accept, one bit per RUN cycle, publish on the last step
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      Ready  <= 1'b1;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Sum    <= '0;
      Cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      Ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            a_sr  <= A;
            b_sr  <= B;
            carry <= Cin;
            cnt   <= '0;
            state <= RUN;
            Ready <= 1'b0;
            Busy  <= 1'b1;
          end else begin
            state <= IDLE;
            Ready <= 1'b1;
            Busy  <= 1'b0;
          end
        end

        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next[WIDTH-1:1];
          carry  <= fa_cout;
          if (cnt == LAST) begin
            // Counter is left at its terminal value; it is cleared on the next accept
            Sum   <= res_next;
            Cout  <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // carry still holds the carry into the MSB during the last step
            Ovf   <= carry ^ fa_cout;
`endif
            Done  <= 1'b1;
            Ready <= 1'b1;
            Busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          Ready <= 1'b1;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=8), Ovf checks under SERIAL_ADD_OVF_EN
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;
  localparam int NVEC  = 10;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Ready;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             Ovf;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         acc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   dones = 0;
  int   expected_dones = 0;
  logic prev_done = 1'b0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Ready (Ready),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every Done pops the oldest expected result
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst && Done) begin
      dones++;
      chk("done_not_consecutive", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no pending operation");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_sum"}, 32'(Sum), 32'(e.sum));
        chk({e.name, "_cout"}, 32'(Cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
        chk({e.name, "_ovf"}, 32'(Ovf), 32'(e.ovf));
`endif
        chk({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(WIDTH + 1));
      end
    end
    prev_done <= Done;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] s, input logic co, input logic ov);
    exp_t e;
    A     = a;
    B     = b;
    Cin   = cin;
    Start = 1'b1;
    e.sum  = s;
    e.cout = co;
    e.ovf  = ov;
    e.acc  = cyc + 1;
    e.name = name;
    sb.push_back(e);
    expected_dones++;
    tick();
    Start = 1'b0;
    A     = 8'($urandom);
    B     = 8'($urandom);
    Cin   = 1'($urandom);
    chk({name, "_busy_after_accept"}, 32'(Busy), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (Done !== 1'b1 && n < 4 * WIDTH) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 32'(Done), 32'd1);
  endtask

  initial begin
    vec_t tbl[NVEC];
    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl[6] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{8'h55, 8'h2A, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[8] = '{8'hFE, 8'hFE, 1'b1, 8'hFD, 1'b1, 1'b0};
    tbl[9] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};

    Rst   = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    tick();
    chk("reset_ready", 32'(Ready), 32'd1);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_sum", 32'(Sum), 32'd0);
    chk("reset_cout", 32'(Cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("reset_ovf", 32'(Ovf), 32'd0);
`endif

    // Table-driven vectors, each from IDLE
    for (int i = 0; i < NVEC; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start_op(nm, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, tbl[i].ovf);
      wait_done(nm);
      tick();
      chk({nm, "_idle_ready"}, 32'(Ready), 32'd1);
    end

    // Start during RUN is ignored; Sum holds the previous result meanwhile
    start_op("ignored", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    tick();
    tick();
    Start = 1'b1;
    A     = 8'hFF;
    B     = 8'hFF;
    Cin   = 1'b1;
    chk("ignored_ready_low", 32'(Ready), 32'd0);
    tick();
    Start = 1'b0;
    chk("ignored_busy", 32'(Busy), 32'd1);
    chk("ignored_sum_held", 32'(Sum), 32'h02);
    wait_done("ignored");
    for (int i = 0; i < WIDTH + 3; i++) tick();
    chk("ignored_idle_busy", 32'(Busy), 32'd0);

    // Back-to-back: second Start issued in the DONE cycle
    start_op("b2b_first", 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    wait_done("b2b_first");
    start_op("b2b_second", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    chk("b2b_sum_held_early", 32'(Sum), 32'h33);
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_sum_held_mid", 32'(Sum), 32'h33);
    wait_done("b2b_second");
    tick();

    // Reset in the middle of RUN discards the operation
    start_op("abort", 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    Rst = 1'b1;
    void'(sb.pop_back());
    expected_dones--;
    tick();
    chk("abort_ready", 32'(Ready), 32'd1);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_sum", 32'(Sum), 32'd0);
    chk("abort_cout", 32'(Cout), 32'd0);
    Rst = 1'b0;
    tick();
    start_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_done("after_abort");
    tick();
    tick();

    chk("done_count", 32'(dones), 32'(expected_dones));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000ns");
    $fatal(1);
  end

endmodule
